// File: rtl/add_share_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit adder between N_REQ requesters,
// with requester locking so multi-word adds can chain their carry word to word.
module add_share_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDW   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_cin,
  input  logic [N_REQ-1:0]       req_chain,
  input  logic [N_REQ-1:0]       req_last,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_cout,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [WIDTH-1:0]       resp_sum,
  output logic                   resp_cout,
  output logic                   resp_ovf,
  output logic                   resp_last
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q;
  logic [IDW-1:0]   lock_id_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic             carry_q;
  logic             resp_valid_q;
  logic [IDW-1:0]   resp_id_q;
  logic [WIDTH-1:0] resp_sum_q;
  logic             resp_cout_q;
  logic             resp_ovf_q;
  logic             resp_last_q;

  logic             slot_free;
  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   grant_id;
  logic             grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IDW-1:0]   rr_ptr_d;
  logic             ovf_d;

  // Round-robin search: descending loop so the closest requester at/after rr_ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
      if (req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // Grant decision, adder drive and next-pointer computation.
  always_comb begin
    slot_free = !resp_valid_q || resp_ready;
    grant_id  = (state_q == LOCKED) ? lock_id_q : winner;
    grant     = !reset && slot_free &&
                ((state_q == LOCKED) ? req_valid[lock_id_q] : found);
    op_a      = req_a[32'(grant_id)*WIDTH +: WIDTH];
    op_b      = req_b[32'(grant_id)*WIDTH +: WIDTH];
    req_ready = grant ? (N_REQ'(1) << grant_id) : '0;
    add_a     = grant ? op_a : '0;
    add_b     = grant ? op_b : '0;
    add_cin   = 1'b0;
    if (grant) begin
      // Stored carry is only meaningful inside a locked transaction.
      add_cin = ((state_q == LOCKED) && req_chain[grant_id]) ? carry_q : req_cin[grant_id];
    end
    rr_ptr_d  = (32'(grant_id) == N_REQ - 1) ? '0 : grant_id + IDW'(1);
    ovf_d     = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_sum[WIDTH-1] != op_a[WIDTH-1]);
  end

  // State, lock, pointer, carry and response register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lock_id_q    <= '0;
      rr_ptr_q     <= '0;
      carry_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_sum_q   <= '0;
      resp_cout_q  <= 1'b0;
      resp_ovf_q   <= 1'b0;
      resp_last_q  <= 1'b0;
    end else if (grant) begin
      resp_valid_q <= 1'b1;
      resp_id_q    <= grant_id;
      resp_sum_q   <= add_sum;
      resp_cout_q  <= add_cout;
      resp_ovf_q   <= ovf_d;
      resp_last_q  <= req_last[grant_id];
      carry_q      <= add_cout;
      if (state_q == IDLE) begin
        rr_ptr_q <= rr_ptr_d;
        if (!req_last[grant_id]) begin
          lock_id_q <= grant_id;
          state_q   <= LOCKED;
        end
      end else if (req_last[grant_id]) begin
        state_q <= IDLE;
      end
    end else if (resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_cout  = resp_cout_q;
  assign resp_ovf   = resp_ovf_q;
  assign resp_last  = resp_last_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter with a behavioural 16-bit adder attached.
module tb_add_share_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned IDW   = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_cin;
  logic [N_REQ-1:0]       req_chain;
  logic [N_REQ-1:0]       req_last;
  logic [WIDTH-1:0]       add_a;
  logic [WIDTH-1:0]       add_b;
  logic                   add_cin;
  logic [WIDTH-1:0]       add_sum;
  logic                   add_cout;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [IDW-1:0]         resp_id;
  logic [WIDTH-1:0]       resp_sum;
  logic                   resp_cout;
  logic                   resp_ovf;
  logic                   resp_last;

  int checks = 0;
  int fails  = 0;

  add_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .req_chain(req_chain), .req_last(req_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_ovf(resp_ovf),
    .resp_last(resp_last)
  );

  // Stand-in for the shared adder instance.
  assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  always #5 clk = ~clk;

  // Packed view of the response: valid, id, sum, cout, ovf, last.
  wire [21:0] resp_vec = {resp_valid, resp_id, resp_sum, resp_cout, resp_ovf, resp_last};

  task automatic set_word(input int i, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic chain, input logic last);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_cin[i]   = cin;
    req_chain[i] = chain;
    req_last[i]  = last;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    req_chain = '0; req_last = '1; resp_ready = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    reset = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    checks++;
    if ({add_a, add_b, add_cin} !== 33'd0) begin
      fails++; $display("FAIL reset_adder_drive: got %h/%h/%b expected zeros", add_a, add_b, add_cin);
    end
    tick();
    checks++;
    if (resp_vec !== 22'd0) begin
      fails++; $display("FAIL reset_resp: got %h expected 000000", resp_vec);
    end
    reset = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    reset_dut();
    for (int i = 0; i < 4; i++) set_word(i, 16'(16'h1000 * (i + 1)), 16'h0000, 1'b0, 1'b0, 1'b1);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      checks++;
      if (req_ready !== exp_rdy) begin
        fails++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp_rdy);
      end
      tick();
      checks++;
      if ({resp_valid, resp_id, resp_sum} !== {1'b1, 2'(k % 4), 16'(16'h1000 * ((k % 4) + 1))}) begin
        fails++; $display("FAIL rr_resp[%0d]: got v=%b id=%0d sum=%h expected v=1 id=%0d", k, resp_valid, resp_id, resp_sum, k % 4);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_arith();
    reset_dut();
    req_valid = 4'b0100;
    set_word(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (resp_vec !== {1'b1, 2'd2, 16'h0000, 1'b1, 1'b0, 1'b1}) begin
      fails++; $display("FAIL arith_wrap: got %h expected %h", resp_vec, {1'b1, 2'd2, 16'h0000, 1'b1, 1'b0, 1'b1});
    end
    set_word(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (resp_vec !== {1'b1, 2'd2, 16'h8000, 1'b0, 1'b1, 1'b1}) begin
      fails++; $display("FAIL arith_ovf: got %h expected %h", resp_vec, {1'b1, 2'd2, 16'h8000, 1'b0, 1'b1, 1'b1});
    end
    req_valid = '0;
  endtask

  task automatic test_chain();
    reset_dut();
    set_word(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    set_word(3, 16'h1234, 16'h0001, 1'b0, 1'b0, 1'b1);
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      fails++; $display("FAIL chain_w0_grant: got %b expected 0010", req_ready);
    end
    tick();
    checks++;
    if (resp_vec !== {1'b1, 2'd1, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
      fails++; $display("FAIL chain_w0_resp: got %h expected %h", resp_vec, {1'b1, 2'd1, 16'h0000, 1'b1, 1'b0, 1'b0});
    end
    // Locked requester drops valid: nobody else may take the adder.
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      fails++; $display("FAIL chain_lock_hold: got %b expected 0000", req_ready);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0) begin
      fails++; $display("FAIL chain_drain: got resp_valid=%b expected 0", resp_valid);
    end
    set_word(1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    req_valid = 4'b1010;
    #1;
    checks++;
    if ({req_ready, add_cin} !== {4'b0010, 1'b1}) begin
      fails++; $display("FAIL chain_w1_grant: got rdy=%b cin=%b expected rdy=0010 cin=1", req_ready, add_cin);
    end
    tick();
    checks++;
    if (resp_vec !== {1'b1, 2'd1, 16'h0001, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL chain_w1_resp: got %h expected %h", resp_vec, {1'b1, 2'd1, 16'h0001, 1'b0, 1'b0, 1'b1});
    end
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      fails++; $display("FAIL chain_release: got %b expected 1000", req_ready);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    reset_dut();
    set_word(0, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b1);
    set_word(1, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
    set_word(2, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1);
    set_word(3, 16'h0007, 16'h0007, 1'b0, 1'b0, 1'b1);
    req_valid = 4'b1111;
    tick();
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        fails++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, req_ready);
      end
      tick();
      checks++;
      if (resp_vec !== {1'b1, 2'd0, 16'h0030, 1'b0, 1'b0, 1'b1}) begin
        fails++; $display("FAIL bp_hold[%0d]: got %h expected %h", k, resp_vec, {1'b1, 2'd0, 16'h0030, 1'b0, 1'b0, 1'b1});
      end
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      fails++; $display("FAIL bp_release_grant: got %b expected 0010", req_ready);
    end
    tick();
    checks++;
    if (resp_vec !== {1'b1, 2'd1, 16'h0003, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL bp_reload: got %h expected %h", resp_vec, {1'b1, 2'd1, 16'h0003, 1'b0, 1'b0, 1'b1});
    end
    req_valid = '0;
  endtask

  task automatic test_reset_locked();
    reset_dut();
    set_word(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    set_word(3, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1);
    req_valid = 4'b0001;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      fails++; $display("FAIL rst_lock_ready: got %b expected 0000", req_ready);
    end
    tick();
    reset = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      fails++; $display("FAIL rst_lock_valid: got %b expected 0", resp_valid);
    end
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      fails++; $display("FAIL rst_lock_free: got %b expected 1000", req_ready);
    end
    tick();
    checks++;
    if (resp_vec !== {1'b1, 2'd3, 16'h0005, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL rst_lock_resp: got %h expected %h", resp_vec, {1'b1, 2'd3, 16'h0005, 1'b0, 1'b0, 1'b1});
    end
    req_valid = '0;
  endtask

  task automatic test_chain_ignored();
    reset_dut();
    set_word(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    req_valid = 4'b0001;
    tick();
    set_word(0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    #1;
    checks++;
    if ({req_ready, add_cin} !== {4'b0001, 1'b0}) begin
      fails++; $display("FAIL chain_ign_cin: got rdy=%b cin=%b expected rdy=0001 cin=0", req_ready, add_cin);
    end
    tick();
    checks++;
    if (resp_vec !== {1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL chain_ign_resp: got %h expected %h", resp_vec, {1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b1});
    end
    req_valid = '0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    req_chain = '0; req_last = '0; resp_ready = 1'b0;
    tick();
    test_reset();
    test_round_robin();
    test_arith();
    test_chain();
    test_backpressure();
    test_reset_locked();
    test_chain_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 16-bit KGP parallel-prefix adder between N requesters.
- Drives the adder operands and carry-in, and captures sum/carry-out into a one-entry response register.
- Supports multi-word chained adds: a requester locks the adder and carry propagates word to word, building 32/48/64-bit adds from the 16-bit datapath.
- Sits between the requesting units and the adder instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 16, adder operand width; must match the adder instance.
- IDW, 2, width of the requester id; equals clog2(N_REQ).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_a  in  N_REQ*WIDTH  operand A; slice i belongs to requester i.
- req_b  in  N_REQ*WIDTH  operand B.
- req_cin  in  N_REQ  carry-in, used when the word is not chained.
- req_chain  in  N_REQ  1 = use the stored carry from this requester's previous word instead of req_cin.
- req_last  in  N_REQ  1 = final word of the transaction; releases the lock.
- add_a  out  WIDTH  to adder.
- add_b  out  WIDTH  to adder.
- add_cin  out  1  to adder.
- add_sum  in  WIDTH  from adder, combinational in the same cycle.
- add_cout  in  1  from adder.
- resp_valid  out  1  response register full.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  IDW  requester that owns the response.
- resp_sum  out  WIDTH  registered sum.
- resp_cout  out  1  registered carry-out.
- resp_ovf  out  1  signed overflow of this word.
- resp_last  out  1  copy of req_last for this word.

Behaviour:
- Reset (synchronous, highest priority, also mid-transaction): resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0, resp_ovf=0, resp_last=0, rr_ptr=0, carry_q=0, state=IDLE, req_ready=0. Any in-flight response and held lock are discarded.
- Slot free: slot_free = !resp_valid | resp_ready. No grant is issued when slot_free=0, and req_ready stays all-zero.
- State IDLE, winner selection: the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping at N_REQ-1 to 0.
- IDLE, on a grant:
  - req_ready[winner]=1 combinationally in the same cycle.
  - Adder is driven with the winner's operands.
  - rr_ptr <= winner+1, wrapping to 0 past N_REQ-1.
  - If req_last[winner]=0: lock_id <= winner and state <= LOCKED.
- State LOCKED:
  - Only lock_id may be granted, when req_valid[lock_id] && slot_free. Other requesters wait even if the adder is idle.
  - A grant with req_last=1 returns the state to IDLE. rr_ptr is unchanged in LOCKED.
- Carry select: add_cin = req_chain[g] ? carry_q : req_cin[g]. carry_q <= add_cout on every grant.
- Chain outside a transaction: req_chain asserted on the first word of a transaction (state IDLE) is ignored and req_cin is used.
- No grant: add_a, add_b and add_cin are driven to 0.
- Registering: on a grant, the response register loads id, add_sum, add_cout, ovf and last. ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]).
- Latency and throughput: accept in cycle N gives resp_valid=1 in cycle N+1. With resp_ready held at 1, throughput is one add per cycle.
- Backpressure: when resp_valid=1 and resp_ready=0, the response fields hold stable and no new grant is issued.
- Drain without refill: resp_ready=1 with no grant clears resp_valid.
- Simultaneous drain and grant: the register reloads and resp_valid stays 1.
- Dropped request: the locked requester deasserting req_valid mid-transaction keeps the lock; the arbiter waits indefinitely.

Test Plan:
- Reset, then req_valid=4'b1111, resp_ready=1 held -> grants 0,1,2,3,0 in consecutive cycles; resp_id follows one cycle later.
- Requester 2 only, a=0xFFFF, b=0x0001, cin=0, last=1 -> next cycle resp_sum=0x0000, resp_cout=1, resp_ovf=0; a=0x7FFF, b=0x0001 -> resp_sum=0x8000, resp_ovf=1.
- 32-bit chain from requester 1: word0 a=0xFFFF b=0x0001 chain=0 last=0, word1 a=0x0000 b=0x0000 chain=1 last=1 -> sums 0x0000 then 0x0001; requester 3 held valid throughout is not granted until after word1.
- resp_ready=0 for 3 cycles with all requesters valid -> resp fields stable, req_ready=0; resp_ready=1 -> the next grant occurs in that same cycle.
- Reset asserted while LOCKED to requester 0 with resp_valid=1 -> next cycle resp_valid=0, state IDLE; requester 3 can then win since rr_ptr=0 and requester 0 is idle.
- req_chain=1 on the first word with carry_q=1 from a prior transaction and req_cin=0, a=b=0 -> resp_sum=0x0000.
